// File: rtl/dec_scan_seq_pkg.sv
// Shared types and constants for the decoder scan sequencer.
// Used by dec_scan_seq and dec_next_addr.
package dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } dec_state_e;

  localparam int DEC_ADDR_W    = 3;
  localparam int DEC_LINES     = 8;
  localparam int DEC_DWELL_DEF = 4;

  // Lowest index whose mask bit is clear; returns 0 when every line is masked.
  function automatic logic [DEC_ADDR_W-1:0] dec_first_free(input logic [DEC_LINES-1:0] m);
    logic [DEC_ADDR_W-1:0] idx;
    idx = {DEC_ADDR_W{1'b0}};
    for (int i = DEC_LINES - 1; i >= 0; i--) begin
      idx = m[i] ? idx : DEC_ADDR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dec_scan_seq_next_addr.sv
// Combinational next-code finder for masked scans: nearest higher unmasked
// index, or the lowest unmasked index with wrap set when none is higher.
module dec_next_addr
  import dec_pkg::*;
(
  input  logic [DEC_ADDR_W-1:0] addr,
  input  logic [DEC_LINES-1:0]  mask,
  output logic [DEC_ADDR_W-1:0] next_addr,
  output logic                  wrap
);

  logic [DEC_ADDR_W-1:0] higher_s;
  logic                  found_s;

  // Descending search so the last hit is the lowest index above addr.
  always_comb begin
    higher_s = {DEC_ADDR_W{1'b0}};
    found_s  = 1'b0;
    for (int i = DEC_LINES - 1; i >= 0; i--) begin
      if ((i > int'(addr)) && !mask[i]) begin
        higher_s = DEC_ADDR_W'(i);
        found_s  = 1'b1;
      end else begin
        higher_s = higher_s;
        found_s  = found_s;
      end
    end
  end

  assign wrap      = ~found_s;
  assign next_addr = found_s ? higher_s : dec_first_free(mask);

endmodule

// File: rtl/dec_scan_seq.sv
// Scan sequencer driving the X/Y/Z/E inputs of a 3-to-8 decoder.
// Optional skip mask enabled by defining DEC_SKIP_MASK_EN.
module dec_scan_seq
  import dec_pkg::*;
#(
  parameter int DWELL = DEC_DWELL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic mode,
  output logic X,
  output logic Y,
  output logic Z,
  output logic E,
  output logic busy,
  output logic done
`ifdef DEC_SKIP_MASK_EN
  ,
  input  logic [DEC_LINES-1:0] mask
`endif
);

  localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  dec_state_e            state_r, state_s;
  logic [DEC_ADDR_W-1:0] addr_r, addr_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  mode_r, mode_s;
  logic [DEC_ADDR_W-1:0] next_addr_s;
  logic                  wrap_s;
  logic [DEC_ADDR_W-1:0] first_s;
  logic                  none_free_s;

`ifdef DEC_SKIP_MASK_EN
  logic [DEC_LINES-1:0]  mask_r, mask_s;

  dec_next_addr u_next_addr (
    .addr      (addr_r),
    .mask      (mask_r),
    .next_addr (next_addr_s),
    .wrap      (wrap_s)
  );

  // First code and the all-masked case are judged on the live mask at start.
  assign first_s     = dec_first_free(mask);
  assign none_free_s = &mask;
`else
  assign next_addr_s = addr_r + DEC_ADDR_W'(1);
  assign wrap_s      = (addr_r == DEC_ADDR_W'(DEC_LINES - 1));
  assign first_s     = {DEC_ADDR_W{1'b0}};
  assign none_free_s = 1'b0;
`endif

  // Next-state, address and dwell-counter logic.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
`ifdef DEC_SKIP_MASK_EN
    mask_s  = mask_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          mode_s = mode;
`ifdef DEC_SKIP_MASK_EN
          mask_s = mask;
`endif
          cnt_s  = {CNT_W{1'b0}};
          if (none_free_s) begin
            state_s = ST_DONE;
            addr_s  = {DEC_ADDR_W{1'b0}};
          end else begin
            state_s = ST_SCAN;
            addr_s  = first_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (stop) begin
          state_s = ST_IDLE;
          addr_s  = {DEC_ADDR_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          cnt_s = {CNT_W{1'b0}};
          if (wrap_s && !mode_r) begin
            state_s = ST_DONE;
            addr_s  = {DEC_ADDR_W{1'b0}};
          end else begin
            addr_s = next_addr_s;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        addr_s  = {DEC_ADDR_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_s = ST_IDLE;
        addr_s  = {DEC_ADDR_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= {DEC_ADDR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      mode_r    <= 1'b0;
`ifdef DEC_SKIP_MASK_EN
      mask_r    <= {DEC_LINES{1'b0}};
`endif
      {X, Y, Z} <= 3'b000;
      E         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      cnt_r     <= cnt_s;
      mode_r    <= mode_s;
`ifdef DEC_SKIP_MASK_EN
      mask_r    <= mask_s;
`endif
      {X, Y, Z} <= (state_s == ST_SCAN) ? addr_s : 3'b000;
      E         <= (state_s == ST_SCAN);
      busy      <= (state_s == ST_SCAN);
      done      <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Self-checking bench for dec_scan_seq: two instances (DWELL=4 and DWELL=1)
// share stimulus and are compared against a cycle-count reference model.
module tb_dec_scan_seq;

  localparam int DW_A = 4;
  localparam int DW_B = 1;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [7:0] mask_in;
  logic       X_a, Y_a, Z_a, E_a, busy_a, done_a;
  logic       X_b, Y_b, Z_b, E_b, busy_b, done_b;

  always #5 clk = ~clk;

  dec_scan_seq #(.DWELL(DW_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .X(X_a), .Y(Y_a), .Z(Z_a), .E(E_a), .busy(busy_a), .done(done_a)
`ifdef DEC_SKIP_MASK_EN
    , .mask(mask_in)
`endif
  );

  dec_scan_seq #(.DWELL(DW_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .X(X_b), .Y(Y_b), .Z(Z_b), .E(E_b), .busy(busy_b), .done(done_b)
`ifdef DEC_SKIP_MASK_EN
    , .mask(mask_in)
`endif
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Reference model: phase 0 idle, 1 scanning, 2 done cycle.
  // t counts cycles since the scan began; code = list[t / dwell].
  int         m_phase[2];
  int         m_t[2];
  int         m_n[2];
  logic       m_mode[2];
  logic [2:0] m_codes[2][8];

  function automatic int dwell_of(input int k);
    return (k == 0) ? DW_A : DW_B;
  endfunction

  function automatic logic [5:0] exp_vec(input int k);
    if (m_phase[k] == 1) return {3'b110, m_codes[k][m_t[k] / dwell_of(k)]};
    else if (m_phase[k] == 2) return 6'b001000;
    else return 6'b000000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
  endtask

  task automatic model_edge(input logic s, input logic p, input logic md,
                            input logic r, input logic [7:0] mk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_phase[k] = 0;
      end else begin
        case (m_phase[k])
          0: if (s && !p) begin
               m_n[k] = 0;
               for (int i = 0; i < 8; i++) begin
                 if (!mk[i]) begin
                   m_codes[k][m_n[k]] = 3'(i);
                   m_n[k]++;
                 end
               end
               m_mode[k]  = md;
               m_t[k]     = 0;
               m_phase[k] = (m_n[k] == 0) ? 2 : 1;
             end
          1: if (p) m_phase[k] = 0;
             else begin
               m_t[k]++;
               if (m_t[k] == m_n[k] * dwell_of(k)) begin
                 if (m_mode[k]) m_t[k] = 0;
                 else m_phase[k] = 2;
               end
             end
          default: m_phase[k] = 0;
        endcase
      end
    end
  endtask

  task automatic check_all();
    logic [5:0] ov[2];
    logic [5:0] ev;
    logic [7:0] q, qe;
    ov[0] = {E_a, busy_a, done_a, X_a, Y_a, Z_a};
    ov[1] = {E_b, busy_b, done_b, X_b, Y_b, Z_b};
    for (int k = 0; k < 2; k++) begin
      ev = exp_vec(k);
      chk(k == 0 ? "model_a" : "model_b", 32'(ov[k]), 32'(ev));
      // Downstream 3-to-8 decoder: one-hot while busy, silent otherwise.
      q  = ov[k][5] ? (8'b1 << ov[k][2:0]) : 8'h00;
      qe = ev[4] ? (8'b1 << ev[2:0]) : 8'h00;
      chk(k == 0 ? "dec_q_a" : "dec_q_b", 32'(q), 32'(qe));
    end
  endtask

  task automatic step(input logic s, input logic p, input logic md,
                      input logic r, input logic [7:0] mk);
    logic [7:0] mk_eff;
    start = s; stop = p; mode = md; rst = r; mask_in = mk;
`ifdef DEC_SKIP_MASK_EN
    mk_eff = mk;
`else
    mk_eff = 8'h00;
`endif
    @(posedge clk);
    cyc++;
    model_edge(s, p, md, r, mk_eff);
    #1;
    check_all();
  endtask

  typedef struct {
    logic       start, stop, mode, rst;
    logic [5:0] exp_a;   // {E, busy, done, X, Y, Z} for the DWELL=4 instance
  } vec_t;

  vec_t tbl[17];
  int   busy_cnt_a, busy_cnt_b, done_cnt_a, done_cnt_b;
  logic [2:0] seen[$];

  initial begin
    m_phase = '{0, 0};
    m_t     = '{0, 0};
    m_n     = '{0, 0};
    m_mode  = '{1'b0, 1'b0};
    start = 1'b0; stop = 1'b0; mode = 1'b0; rst = 1'b1; mask_in = 8'h00;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};  // reset
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};  // start+stop: stay idle
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000000};  // stop in idle
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b110000};  // start -> code 0
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110000};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110000};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110001};  // code 1 after 4 cycles
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b110001};  // start mid-scan ignored
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b110001};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b110001};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110010};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};  // reset mid-scan
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b110000};  // restart from code 0
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000000};  // stop -> idle
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].start, tbl[i].stop, tbl[i].mode, tbl[i].rst, 8'h00);
      chk($sformatf("tbl_row%0d", i), 32'({E_a, busy_a, done_a, X_a, Y_a, Z_a}),
          32'(tbl[i].exp_a));
    end

    // Full single-shot scan: busy for 8*DWELL cycles, exactly one done pulse.
    busy_cnt_a = 0; busy_cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 40; i++) begin
      busy_cnt_a += int'(busy_a); busy_cnt_b += int'(busy_b);
      done_cnt_a += int'(done_a); done_cnt_b += int'(done_b);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    end
    chk("single_busy_a", 32'(busy_cnt_a), 32'(8 * DW_A));
    chk("single_done_a", 32'(done_cnt_a), 32'd1);
    chk("single_busy_b", 32'(busy_cnt_b), 32'(8 * DW_B));
    chk("single_done_b", 32'(done_cnt_b), 32'd1);
    chk("single_end_idle", 32'({E_a, busy_a, done_a, X_a, Y_a, Z_a}), 32'd0);

    // Continuous mode across several wraps, then stop at code 5.
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 40 && {X_a, Y_a, Z_a} != 3'd5; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("cont_reach5", 32'({E_a, X_a, Y_a, Z_a}), 32'({1'b1, 3'd5}));
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("stop_E", 32'({E_a, busy_a}), 32'd0);
    done_cnt_a = int'(done_a);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      done_cnt_a += int'(done_a);
    end
    chk("stop_no_done", 32'(done_cnt_a), 32'd0);

`ifdef DEC_SKIP_MASK_EN
    // Masked single-shot visits 1,3,4,6; live mask changes afterwards are ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    done_cnt_a = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy_a && (seen.size() == 0 || seen[$] != {X_a, Y_a, Z_a}))
        seen.push_back({X_a, Y_a, Z_a});
      done_cnt_a += int'(done_a);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk("mask_len", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("mask_seq", 32'({seen[0], seen[1], seen[2], seen[3]}),
          32'({3'd1, 3'd3, 3'd4, 3'd6}));
    end else begin
      chk("mask_seq", 32'(seen.size()), 32'd4);
    end
    chk("mask_done", 32'(done_cnt_a), 32'd1);
    // All masked: done pulse right after start, enable never asserted.
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    chk("mask_ff_done", 32'({E_a, busy_a, done_a}), 32'b001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
    chk("mask_ff_after", 32'({E_a, busy_a, done_a}), 32'b000);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] mk;
      mk = 8'($urandom);
      if ($urandom_range(0, 9) == 0) mk = 8'hFF;
      step($urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 300) == 0, mk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dec_scan_seq.md
# dec_scan_seq

Scan sequencer that drives the select inputs of the 3-to-8 decoder (`dec_3x8`) directly upstream of it. On request it walks the 3-bit select code 0→7, holding each code for a programmable dwell time with the decoder enable asserted. It runs either single-shot or continuously. Its X/Y/Z/E outputs connect one-to-one to the decoder's X/Y/Z/E inputs, so exactly one decoder output line is high while a scan is active.

## Interface
- `DWELL`, default 4: cycles each select code is held; legal range 1..256.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle scan request; honoured only in IDLE.
- `stop`  in  1  abort request; honoured in SCAN; dominates `start`.
- `mode`  in  1  0 = single-shot, 1 = continuous; latched when `start` is accepted.
- `X`  out  1  select bit 2 (MSB), to decoder X.
- `Y`  out  1  select bit 1, to decoder Y.
- `Z`  out  1  select bit 0 (LSB), to decoder Z.
- `E`  out  1  decoder enable; high only in SCAN.
- `busy`  out  1  high in SCAN.
- `done`  out  1  one-cycle pulse when a single-shot scan completes.
- `mask`  in  8  skip mask; present only with `DEC_SKIP_MASK_EN`.

## Operation
- States: IDLE, SCAN, DONE. All outputs are registered.
- Reset: state IDLE; `X`/`Y`/`Z`/`E`/`busy`/`done` = 0; address = 0; dwell counter = 0; latched mode = 0.
- IDLE: when `start`=1 and `stop`=0, latch `mode` and go to SCAN with address 0. In all other cases stay in IDLE.
- SCAN: `E`=1, `busy`=1, and {X,Y,Z} = address. The dwell counter counts 0..DWELL-1. On terminal count:
  - If address < 7: address+1 and the counter clears.
  - If address = 7 and latched mode=1: address wraps to 0.
  - If address = 7 and latched mode=0: go to DONE.
- DONE: `E`=0, `busy`=0, `done`=1 for exactly one cycle, {X,Y,Z}=0. Next state is IDLE unconditionally. `start` is ignored in DONE.
- `stop` in SCAN: next cycle is IDLE with `E`=0, address=0, and no `done` pulse. `stop` in IDLE or DONE has no effect.
- `start` while in SCAN or DONE is ignored. `mode` changes during a scan are ignored.
- Dwell counter width is max(1, $clog2(DWELL)). With DWELL=1 the address advances every cycle.
- Invariant: `E`=1 exactly when state is SCAN. The decoder therefore never has an output high outside a scan.

## Timing
- Latency: `start` sampled at edge n → `E`=1 and {X,Y,Z}=0 from edge n+1.
- Each code is held exactly DWELL cycles. A single-shot scan has `busy` high for 8·DWELL cycles, followed by `done` high for 1 cycle.
- The earliest accepted restart is `start` sampled in the cycle after DONE, because the sequencer is in IDLE by then.
- Continuous mode has no gap cycle at the wrap: code 7 is followed directly by code 0.
- `stop` sampled at edge n → `E`=0 from edge n+1.
- `rst` dominates everything. Reset asserted mid-scan drops `E` on the next edge.

## Configuration
- `DEC_SKIP_MASK_EN` defined: adds the `mask` input, latched together with `mode` at `start`.
  - Addresses whose mask bit is 1 are skipped.
  - The first code is the lowest unmasked index.
  - The next code is the next higher unmasked index. If no higher index is unmasked, the scan wraps (continuous) or goes to DONE (single-shot).
  - If mask = 8'hFF at `start`, go directly to DONE (one `done` pulse, `E` never asserted) regardless of mode.
- `DEC_SKIP_MASK_EN` undefined: no `mask` port; all 8 codes are visited in order.

## Structure
- Shared package `dec_pkg` contains:
  - State enum (IDLE/SCAN/DONE).
  - `DEC_ADDR_W`=3 and `DEC_LINES`=8.
  - `DWELL` default constant.
- One sub-module, `dec_next_addr` (combinational). Given the current address and latched mask, it outputs the next unmasked index and a `wrap` flag. It is instantiated only under `DEC_SKIP_MASK_EN`; otherwise next = address+1 and wrap = (address==7).

## Test plan
- Reset, then DWELL=4, mode=0, `start` pulse → {X,Y,Z} steps 0..7 with 4 cycles each and `E`=1 for 32 cycles; `done`=1 for one cycle; back to IDLE with all outputs 0.
- mode=1, DWELL=1 → sequence 0..7,0,1,… with no gap at the wrap. `stop` while address=5 → `E`=0 the next cycle and no `done` pulse.
- `start` and `stop` asserted together in IDLE → stays in IDLE, `E` stays 0. `start` pulsed mid-scan → no restart and the sequence is undisturbed.
- `rst` asserted at address 3 → next cycle all outputs 0. A subsequent `start` scans from code 0.
- With `DEC_SKIP_MASK_EN`: mask=8'b1010_0101, single-shot → codes 1,3,4,6, then `done`. mask=8'hFF → `done` pulse the cycle after the start is accepted, `E` never high.
- Connect to `dec_3x8`: on every cycle, decoder Q has exactly one bit set (Q == 1<<{X,Y,Z}) while `busy`=1, and Q==0 otherwise.
